exec_controller: RTL and testbench
==================================

# exec_controller

Execution controller for the multicycle MIPS core. It gates the core's per-cycle enable (`cpu_en`) so the processor can run freely, single-step one instruction at a time, or stop on a PC breakpoint. It sits beside `control_unit`/`datapath` in the top level and watches the control FSM state and PC. It also keeps cycle and instruction counters for the debug display.

## Interface
Parameters:
- `FETCH_ST`, 4'd0: control_unit state code for instruction fetch; this is the instruction boundary.
- `CW`, 32: counter width.

Ports:
- `clk`  in  1: single clock.
- `rst`  in  1: reset, synchronous, active-high.
- `run_sw`  in  1: level; 1 = free run requested.
- `step_btn`  in  1: debounced, already synchronous to `clk`; each rising edge requests one instruction.
- `bp_en`  in  1: breakpoint enable.
- `bp_addr`  in  32: breakpoint PC.
- `state`  in  4: current control_unit state (registered in the core).
- `pc`  in  32: current PC (registered in the core).
- `cpu_en`  out  1: core advances (state reg, PC, IR, regfile, memory writes) only when 1; combinational.
- `halted`  out  1: 1 in HALT or BREAK.
- `mode`  out  2: current controller state.
- `cycle_count`  out  CW: enabled-cycle count.
- `instr_count`  out  CW: instructions started.

## Operation
- Controller FSM states: HALT=0, RUN=1, STEP=2, BREAK=3. Reset state is HALT.
- `step_rise` = `step_btn` & ~`step_q`, where `step_q` is `step_btn` registered.
- `bp_hit` = `bp_en` & (`state`==FETCH_ST) & (`pc`==`bp_addr`) & ~`skip_bp`.
- `at_fetch` = (`state`==FETCH_ST).
- HALT:
  - `cpu_en`=0.
  - If `run_sw` → RUN, and set `skip_bp`.
  - Else if `step_rise` → STEP, and set `skip_bp` and clear `stepped`. `run_sw` has priority over `step_rise`.
- RUN:
  - `cpu_en` = ~`bp_hit` & ~(~`run_sw` & `at_fetch`).
  - If `bp_hit` → BREAK.
  - Else if ~`run_sw` & `at_fetch` → HALT.
  - A deasserted `run_sw` mid-instruction lets the instruction finish; the stop takes effect at the next fetch.
- STEP:
  - If `at_fetch` & `stepped` → HALT, with `cpu_en`=0.
  - Otherwise `cpu_en`=1, and `stepped` is set on the first enabled cycle.
  - Breakpoints are ignored in STEP.
- BREAK:
  - `cpu_en`=0.
  - `step_rise` → STEP, with `skip_bp` set.
  - ~`run_sw` → HALT.
  - `step_rise` has priority over ~`run_sw`.
  - With `run_sw` still 1 and no step request, stay in BREAK. The user must drop and re-raise `run_sw` to resume.
- `skip_bp` is cleared on the first cycle with `cpu_en`=1 & `at_fetch`. A resume at the breakpoint PC therefore proceeds exactly once.
- Counters:
  - `cycle_count` += 1 on every cycle with `cpu_en`=1.
  - `instr_count` += 1 on every cycle with `cpu_en` & `at_fetch`.
  - Both wrap modulo 2^CW and hold otherwise.
- `halted` = (mode==HALT)|(mode==BREAK).

## Timing
- Reset values (cycle after `rst` high):
  - mode=HALT, `cpu_en`=0, `halted`=1.
  - Counters 0; `skip_bp`=0, `stepped`=0, `step_q`=0.
- `rst` mid-instruction aborts any mode and returns to HALT. The core is reset on the same `rst`, so `state` returns to FETCH_ST.
- `cpu_en` is combinational from registered FSM state and the core's registered `state`/`pc`. There is no combinational loop.
- `cpu_en` must be valid within the same cycle.
- Latency:
  - `step_rise` → `cpu_en`=1 on the next cycle.
  - Breakpoint stop has zero cycles: the matching fetch is never enabled.
- A step edge while in RUN or STEP is ignored, but still updates `step_q`.
- One step of an instruction taking N core states gives exactly N enabled cycles, `instr_count`+1, and `cycle_count`+N.

## Structure
- `mips_pkg` holds:
  - `exec_mode_t` enum (HALT, RUN, STEP, BREAK; 2 bits).
  - `FETCH_ST` localparam, shared with control_unit so the codes cannot drift.
- Sub-module `rise_detect` (1-bit register plus AND) for `step_btn`. It is reusable for other board buttons.
- The top level must route `cpu_en` into `control_unit` (state register enable) and into every `datapath` write/enable, ANDed with the existing PCEn, MemWrite, IRWrite and RegWrite.

## Test plan
- Reset, `run_sw`=0, 10 cycles → `cpu_en`=0, `halted`=1, mode=0, both counts 0.
- `run_sw`=1, then drop `run_sw` while `state`=3 → `cpu_en` stays 1 until `state`=FETCH_ST, then mode=HALT. `instr_count` equals the fetches observed.
- From HALT, one `step_btn` pulse on an R-type (4 states) → exactly 4 `cpu_en` cycles, `instr_count`+1, `cycle_count`+4, back in HALT at FETCH_ST.
- `bp_en`=1, `bp_addr`=0x0000_0008, run → halts with `pc`=0x8, `state`=FETCH_ST, mode=BREAK, `cpu_en`=0 with no fetch enabled. A step pulse then executes the 0x8 instruction; `pc` advances to 0xC and mode=HALT.
- In BREAK, `run_sw` 1→0→1 → resumes RUN without re-triggering at 0x8. A later return to 0x8 breaks again.
- Preload `cycle_count` to 2^32−1 (via a force) and run 1 cycle → wraps to 0. Assert `rst` mid-STEP → mode=HALT next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS core and its execution controller.
package mips_pkg;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    STEP  = 2'd2,
    BREAK = 2'd3
  } exec_mode_t;

  // control_unit fetch state; the instruction boundary seen by the controller
  localparam logic [3:0] FETCH_ST = 4'd0;

endpackage

// File: rtl/rise_detect.sv
// Registered rising-edge detector for an already-synchronous level input.
module rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic din_q;
  logic din_d;

  always_comb begin
    din_d = din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      din_q <= 1'b0;
    end else begin
      din_q <= din_d;
    end
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/exec_controller.sv
// Run / single-step / PC-breakpoint gating of the core's per-cycle enable,
// plus enabled-cycle and instruction counters for the debug display.
//
// state | meaning
// HALT  | core frozen, waiting for run_sw or a step edge
// RUN   | free run until breakpoint or run_sw low at a fetch
// STEP  | run exactly one instruction, stop at the next fetch
// BREAK | stopped on bp_addr; step resumes one, run_sw low releases
module exec_controller #(
  parameter logic [3:0] FETCH_ST = mips_pkg::FETCH_ST,
  parameter int         CW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run_sw,
  input  logic          step_btn,
  input  logic          bp_en,
  input  logic [31:0]   bp_addr,
  input  logic [3:0]    state,
  input  logic [31:0]   pc,
  output logic          cpu_en,
  output logic          halted,
  output logic [1:0]    mode,
  output logic [CW-1:0] cycle_count,
  output logic [CW-1:0] instr_count
);

  mips_pkg::exec_mode_t mode_q, mode_d;
  logic                 skip_bp_q, skip_bp_d;
  logic                 stepped_q, stepped_d;
  logic [CW-1:0]        cycle_count_q, cycle_count_d;
  logic [CW-1:0]        instr_count_q, instr_count_d;

  logic step_rise;
  logic at_fetch;
  logic bp_hit;

  rise_detect u_step_rise (
    .clk  (clk),
    .rst  (rst),
    .din  (step_btn),
    .rise (step_rise)
  );

  assign at_fetch = (state == FETCH_ST);
  assign bp_hit   = bp_en & at_fetch & (pc == bp_addr) & ~skip_bp_q;

  always_comb begin
    mode_d    = mode_q;
    skip_bp_d = skip_bp_q;
    stepped_d = stepped_q;
    cpu_en    = 1'b0;

    case (mode_q)
      mips_pkg::HALT: begin
        if (run_sw) begin
          mode_d    = mips_pkg::RUN;
          skip_bp_d = 1'b1;
        end else if (step_rise) begin
          mode_d    = mips_pkg::STEP;
          skip_bp_d = 1'b1;
          stepped_d = 1'b0;
        end
      end
      mips_pkg::RUN: begin
        // a low run_sw only stops at an instruction boundary
        cpu_en = ~bp_hit & ~(~run_sw & at_fetch);
        if (bp_hit) begin
          mode_d = mips_pkg::BREAK;
        end else if (~run_sw & at_fetch) begin
          mode_d = mips_pkg::HALT;
        end
      end
      mips_pkg::STEP: begin
        if (at_fetch & stepped_q) begin
          mode_d = mips_pkg::HALT;
        end else begin
          cpu_en    = 1'b1;
          stepped_d = 1'b1;
        end
      end
      mips_pkg::BREAK: begin
        if (step_rise) begin
          mode_d    = mips_pkg::STEP;
          skip_bp_d = 1'b1;
          stepped_d = 1'b0;
        end else if (~run_sw) begin
          mode_d = mips_pkg::HALT;
        end
      end
      default: mode_d = mips_pkg::HALT;
    endcase

    // the resumed fetch at the breakpoint PC consumes the skip
    if (cpu_en & at_fetch) begin
      skip_bp_d = 1'b0;
    end

    cycle_count_d = cycle_count_q + {{(CW-1){1'b0}}, cpu_en};
    instr_count_d = instr_count_q + {{(CW-1){1'b0}}, cpu_en & at_fetch};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q        <= mips_pkg::HALT;
      skip_bp_q     <= 1'b0;
      stepped_q     <= 1'b0;
      cycle_count_q <= '0;
      instr_count_q <= '0;
    end else begin
      mode_q        <= mode_d;
      skip_bp_q     <= skip_bp_d;
      stepped_q     <= stepped_d;
      cycle_count_q <= cycle_count_d;
      instr_count_q <= instr_count_d;
    end
  end

  assign mode        = mode_q;
  assign halted      = (mode_q == mips_pkg::HALT) | (mode_q == mips_pkg::BREAK);
  assign cycle_count = cycle_count_q;
  assign instr_count = instr_count_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench: a 4-state-per-instruction core model looping over
// PCs 0x0..0x10 drives state/pc, gated by the controller's cpu_en.
module tb_exec_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run_sw;
  logic        step_btn;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [3:0]  state;
  logic [31:0] pc;
  logic        cpu_en;
  logic        halted;
  logic [1:0]  mode;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;

  int n_cmp = 0;
  int n_bad = 0;
  int en_cnt;

  exec_controller #(.FETCH_ST(4'd0), .CW(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .run_sw      (run_sw),
    .step_btn    (step_btn),
    .bp_en       (bp_en),
    .bp_addr     (bp_addr),
    .state       (state),
    .pc          (pc),
    .cpu_en      (cpu_en),
    .halted      (halted),
    .mode        (mode),
    .cycle_count (cycle_count),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) begin
      state <= 4'd0;
      pc    <= 32'h0;
    end else if (cpu_en) begin
      if (state == 4'd3) begin
        state <= 4'd0;
        pc    <= (pc == 32'h10) ? 32'h0 : pc + 32'd4;
      end else begin
        state <= state + 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_mode(input string tag, input logic [1:0] m, input int limit);
    int i;
    i = 0;
    while (mode !== m && i < limit) begin
      tick();
      i++;
    end
    chk(tag, 32'(mode), 32'(m));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run_sw = 1'b0; step_btn = 1'b0; bp_en = 1'b0; bp_addr = 32'h0;
    repeat (3) tick();
    rst = 1'b0;
    repeat (10) tick();
    chk("rst_cpu_en", 32'(cpu_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd1);
    chk("rst_mode", 32'(mode), 32'd0);
    chk("rst_cycles", cycle_count, 32'd0);
    chk("rst_instrs", instr_count, 32'd0);

    // free run, drop run_sw mid-instruction at pc 0x4 state 3
    run_sw = 1'b1;
    tick();
    chk("run_mode", 32'(mode), 32'd1);
    chk("run_cpu_en", 32'(cpu_en), 32'd1);
    repeat (7) tick();
    chk("run_state3", 32'(state), 32'd3);
    chk("run_cycles7", cycle_count, 32'd7);
    chk("run_instrs2", instr_count, 32'd2);
    run_sw = 1'b0;
    #1;
    chk("drop_mid_en", 32'(cpu_en), 32'd1);
    tick();
    chk("drop_fetch_en", 32'(cpu_en), 32'd0);
    chk("drop_fetch_mode", 32'(mode), 32'd1);
    tick();
    chk("drop_halt_mode", 32'(mode), 32'd0);
    chk("drop_halt_pc", pc, 32'h8);
    chk("drop_cycles", cycle_count, 32'd8);
    chk("drop_instrs", instr_count, 32'd2);

    // single step of the 0x8 instruction
    step_btn = 1'b1;
    en_cnt = 0;
    repeat (8) begin tick(); en_cnt += int'(cpu_en); end
    chk("step_en_cycles", 32'(en_cnt), 32'd4);
    chk("step_mode", 32'(mode), 32'd0);
    chk("step_pc", pc, 32'hC);
    chk("step_state", 32'(state), 32'd0);
    chk("step_cycles", cycle_count, 32'd12);
    chk("step_instrs", instr_count, 32'd3);
    step_btn = 1'b0;

    // breakpoint at 0x8
    bp_en = 1'b1; bp_addr = 32'h8; run_sw = 1'b1;
    tick();
    wait_mode("bp_wait", 2'd3, 40);
    chk("bp_pc", pc, 32'h8);
    chk("bp_state", 32'(state), 32'd0);
    chk("bp_cpu_en", 32'(cpu_en), 32'd0);
    chk("bp_halted", 32'(halted), 32'd1);
    chk("bp_cycles", cycle_count, 32'd28);
    chk("bp_instrs", instr_count, 32'd7);

    // step out of BREAK (run_sw dropped so HALT holds afterwards)
    step_btn = 1'b1; run_sw = 1'b0;
    en_cnt = 0;
    repeat (6) begin tick(); en_cnt += int'(cpu_en); end
    chk("bpstep_en_cycles", 32'(en_cnt), 32'd4);
    chk("bpstep_mode", 32'(mode), 32'd0);
    chk("bpstep_pc", pc, 32'hC);
    chk("bpstep_cycles", cycle_count, 32'd32);
    chk("bpstep_instrs", instr_count, 32'd8);
    step_btn = 1'b0;

    // break again, then resume by toggling run_sw
    run_sw = 1'b1;
    tick();
    wait_mode("bp2_wait", 2'd3, 40);
    chk("bp2_pc", pc, 32'h8);
    chk("bp2_cycles", cycle_count, 32'd48);
    chk("bp2_instrs", instr_count, 32'd12);
    run_sw = 1'b0;
    tick();
    chk("resume_halt", 32'(mode), 32'd0);
    run_sw = 1'b1;
    tick();
    chk("resume_mode", 32'(mode), 32'd1);
    chk("resume_en_at_bp", 32'(cpu_en), 32'd1);
    chk("resume_pc", pc, 32'h8);
    wait_mode("bp3_wait", 2'd3, 60);
    chk("bp3_pc", pc, 32'h8);
    chk("bp3_cycles", cycle_count, 32'd68);
    chk("bp3_instrs", instr_count, 32'd17);

    // cycle counter wrap
    run_sw = 1'b0;
    tick();
    run_sw = 1'b1;
    tick();
    chk("wrap_pre_en", 32'(cpu_en), 32'd1);
    force dut.cycle_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_count_q;
    tick();
    chk("wrap_cycles", cycle_count, 32'd0);
    chk("wrap_instrs", instr_count, 32'd18);

    // reset in the middle of a step
    run_sw = 1'b0;
    wait_mode("stop_wait", 2'd0, 20);
    step_btn = 1'b1;
    tick();
    tick();
    chk("midstep_mode", 32'(mode), 32'd2);
    rst = 1'b1;
    tick();
    chk("rststep_mode", 32'(mode), 32'd0);
    chk("rststep_cpu_en", 32'(cpu_en), 32'd0);
    chk("rststep_halted", 32'(halted), 32'd1);
    chk("rststep_cycles", cycle_count, 32'd0);
    chk("rststep_instrs", instr_count, 32'd0);
    rst = 1'b0;
    step_btn = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
